// File: rtl/pm_loader.sv
// pm_loader -- boot-time program memory loader for the 8-bit processor.
//
// Accepts a framed byte stream from a host over valid/ready and writes the
// instruction bytes into program memory starting at address 0. The core is
// held in reset (cpu_reset high) while a frame is loading. It is released
// only after a frame's checksum matches.
//
// Frame: 0xA5, LEN, LEN data bytes, CSUM (8-bit modular sum of data bytes).
//
// Parameters:
//   ADDR_W       program memory address width (1..8)
//   TIMEOUT_CYC  max idle cycles between bytes inside a frame (>= 2)
//
// Ports:
//   clk          single clock
//   sync_reset   synchronous active-high reset
//   rx_data      host byte
//   rx_valid     rx_data is valid
//   rx_ready     loader accepts a byte this cycle (combinational)
//   pm_we        program memory write strobe (registered)
//   pm_wr_addr   program memory write address (registered)
//   pm_wr_data   instruction byte to write (registered)
//   cpu_reset    drives the core's sync_reset; high holds the core (registered)
//   busy         a frame is in progress (combinational from state)
//   load_done    one-cycle pulse on a successful load (registered)
//   load_err     level: the last frame failed (registered)

module pm_loader #(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic              clk,
    input  logic              sync_reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              pm_we,
    output logic [ADDR_W-1:0] pm_wr_addr,
    output logic [7:0]        pm_wr_data,
    output logic              cpu_reset,
    output logic              busy,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [7:0] HEADER  = 8'hA5;
    localparam int         TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam int         LEN_MAX = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state;
    logic [ADDR_W:0] len_q;     // one extra bit so LEN = 2^ADDR_W is representable
    logic [ADDR_W:0] addr_q;    // counts written bytes; low bits drive pm_wr_addr
    logic [7:0]      sum_q;
    logic [TO_W-1:0] idle_cnt;
    logic            in_frame;
    logic            xfer;
    logic [8:0]      rx_ext;

    assign in_frame = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
    assign busy     = in_frame;
    assign rx_ready = !sync_reset && (state != S_DONE);
    assign xfer     = rx_valid && rx_ready;
    assign rx_ext   = {1'b0, rx_data};

    // NOTE: all state below is sequential and uses non-blocking assignments,
    // so every branch sees the pre-edge values of the other registers.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state      <= S_IDLE;
            len_q      <= '0;
            addr_q     <= '0;
            sum_q      <= '0;
            idle_cnt   <= '0;
            pm_we      <= 1'b0;
            pm_wr_addr <= '0;
            pm_wr_data <= '0;
            cpu_reset  <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            // Strobes default low so they are single-cycle pulses.
            pm_we     <= 1'b0;
            load_done <= 1'b0;

            // Inter-byte idle counter only runs while a frame is open.
            if (!in_frame || xfer) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (xfer && rx_data == HEADER) begin
                        state     <= S_LEN;
                        cpu_reset <= 1'b1;
                    end
                end

                S_LEN: begin
                    if (xfer) begin
                        if (rx_data == 8'h00 || rx_ext > 9'(LEN_MAX)) begin
                            state    <= S_ERR;
                            load_err <= 1'b1;
                        end else begin
                            len_q  <= rx_ext[ADDR_W:0];
                            addr_q <= '0;
                            sum_q  <= '0;
                            state  <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (xfer) begin
                        pm_we      <= 1'b1;
                        pm_wr_addr <= addr_q[ADDR_W-1:0];
                        pm_wr_data <= rx_data;
                        addr_q     <= addr_q + 1'b1;
                        sum_q      <= sum_q + rx_data;
                        if (addr_q + 1'b1 == len_q) begin
                            state <= S_CSUM;
                        end
                    end
                end

                S_CSUM: begin
                    if (xfer) begin
                        if (rx_data == sum_q) begin
                            state     <= S_DONE;
                            load_done <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state    <= S_ERR;
                            load_err <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                S_ERR: begin
                    // Sticky: only a fresh header restarts, holding the core again.
                    if (xfer && rx_data == HEADER) begin
                        state     <= S_LEN;
                        load_err  <= 1'b0;
                        cpu_reset <= 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase

            // The counter reaches TIMEOUT_CYC on this edge, so abort now.
            // Only fires without a transfer, so it never races the case above.
            if (in_frame && !xfer && idle_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                state    <= S_ERR;
                load_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pm_loader.sv
// tb_pm_loader -- directed self-checking bench for pm_loader.
//
// Two instances share the same stimulus: dut8 (defaults) and dut4
// (ADDR_W=4, TIMEOUT_CYC=10). The instance under observation is chosen by
// 'sel'. Both are reset at the start of every scenario. A negedge monitor
// records every write strobe and load_done pulse of the observed instance.

module tb_pm_loader;

    logic       clk = 1'b0;
    logic       sync_reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       sel;

    logic       r8, we8, cr8, b8, ld8, le8;
    logic [7:0] a8, d8;
    logic       r4, we4, cr4, b4, ld4, le4;
    logic [3:0] a4;
    logic [7:0] d4;

    logic       o_rx_ready, o_pm_we, o_cpu_reset, o_busy, o_load_done, o_load_err;
    logic [7:0] o_pm_wr_addr, o_pm_wr_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0;
    logic [7:0] w_addr[$];
    logic [7:0] w_data[$];
    int         w_cyc[$];
    logic [7:0] seq[$];

    pm_loader dut8 (
        .clk(clk), .sync_reset(sync_reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(r8), .pm_we(we8), .pm_wr_addr(a8), .pm_wr_data(d8),
        .cpu_reset(cr8), .busy(b8), .load_done(ld8), .load_err(le8)
    );

    pm_loader #(.ADDR_W(4), .TIMEOUT_CYC(10)) dut4 (
        .clk(clk), .sync_reset(sync_reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(r4), .pm_we(we4), .pm_wr_addr(a4), .pm_wr_data(d4),
        .cpu_reset(cr4), .busy(b4), .load_done(ld4), .load_err(le4)
    );

    assign o_rx_ready   = sel ? r4  : r8;
    assign o_pm_we      = sel ? we4 : we8;
    assign o_pm_wr_addr = sel ? {4'h0, a4} : a8;
    assign o_pm_wr_data = sel ? d4  : d8;
    assign o_cpu_reset  = sel ? cr4 : cr8;
    assign o_busy       = sel ? b4  : b8;
    assign o_load_done  = sel ? ld4 : ld8;
    assign o_load_err   = sel ? le4 : le8;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_pm_we === 1'b1) begin
            w_addr.push_back(o_pm_wr_addr);
            w_data.push_back(o_pm_wr_data);
            w_cyc.push_back(cyc);
        end
        if (o_load_done === 1'b1) done_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        w_addr.delete();
        w_data.delete();
        w_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic do_reset(input logic s);
        sel        = s;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        sync_reset = 1'b1;
        tick();
        tick();
        sync_reset = 1'b0;
        clear_mon();
    endtask

    // Present one byte and hold it until the observed DUT accepts it.
    // Returns one time unit after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n        = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (o_rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (o_rx_ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL send_stall byte=%02h rx_ready never rose", b);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] v;
        sel        = 1'b0;
        sync_reset = 1'b1;
        rx_valid   = 1'b1;
        rx_data    = 8'hA5;
        tick();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #0;
            v = {o_cpu_reset, o_pm_we, o_load_done, o_load_err, o_busy, o_rx_ready};
            total++; if (v !== 6'b100000) begin bad++; $display("FAIL reset_flags sel=%0d got=%06b exp=100000", s, v); end
            total++; if (o_pm_wr_addr !== 8'h00 || o_pm_wr_data !== 8'h00) begin bad++; $display("FAIL reset_addr_data sel=%0d got=%02h/%02h exp=00/00", s, o_pm_wr_addr, o_pm_wr_data); end
        end
        rx_valid   = 1'b0;
        sync_reset = 1'b0;
        #1;
        total++; if (o_rx_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%0b exp=1", o_rx_ready); end
        tick();
    endtask

    task automatic test_good_frame();
        logic [7:0] dat[3];
        logic [3:0] v;
        dat = '{8'h05, 8'h83, 8'hE0};
        do_reset(1'b0);
        send_byte(8'hA5);
        total++; if (o_cpu_reset !== 1'b1 || o_busy !== 1'b1) begin bad++; $display("FAIL good_hdr cpu_reset/busy got=%0b%0b exp=11", o_cpu_reset, o_busy); end
        send_byte(8'h03);
        total++; if (o_pm_we !== 1'b0) begin bad++; $display("FAIL good_len_no_we got=%0b exp=0", o_pm_we); end
        for (int i = 0; i < 3; i++) begin
            send_byte(dat[i]);
            total++;
            if (o_pm_we !== 1'b1 || o_pm_wr_addr !== 8'(i) || o_pm_wr_data !== dat[i]) begin
                bad++;
                $display("FAIL good_write%0d got we=%0b a=%02h d=%02h exp we=1 a=%02h d=%02h", i, o_pm_we, o_pm_wr_addr, o_pm_wr_data, i, dat[i]);
            end
        end
        send_byte(8'h68);
        v = {o_load_done, o_cpu_reset, o_rx_ready, o_busy};
        total++; if (v !== 4'b1000) begin bad++; $display("FAIL good_done done/cpu_rst/ready/busy got=%04b exp=1000", v); end
        tick();
        v = {o_load_done, o_cpu_reset, o_rx_ready, o_busy};
        total++; if (v !== 4'b0010) begin bad++; $display("FAIL good_after done/cpu_rst/ready/busy got=%04b exp=0010", v); end
        total++; if (w_addr.size() !== 3) begin bad++; $display("FAIL good_wr_count got=%0d exp=3", w_addr.size()); end
        if (w_cyc.size() == 3) begin
            total++; if (w_cyc[1] !== w_cyc[0] + 1 || w_cyc[2] !== w_cyc[1] + 1) begin bad++; $display("FAIL good_b2b cycles got=%0d,%0d,%0d exp consecutive", w_cyc[0], w_cyc[1], w_cyc[2]); end
        end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL good_done_count got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_bad_csum();
        do_reset(1'b0);
        seq = '{8'hA5, 8'h03, 8'h05, 8'h83, 8'hE0, 8'h69};
        foreach (seq[i]) send_byte(seq[i]);
        total++; if (o_load_err !== 1'b1 || o_cpu_reset !== 1'b1 || o_busy !== 1'b0) begin bad++; $display("FAIL bad_err err/cpu_rst/busy got=%0b%0b%0b exp=110", o_load_err, o_cpu_reset, o_busy); end
        total++; if (w_addr.size() !== 3 || done_cnt !== 0) begin bad++; $display("FAIL bad_writes got writes=%0d done=%0d exp 3/0", w_addr.size(), done_cnt); end
        send_byte(8'h77);
        tick();
        total++; if (o_load_err !== 1'b1 || o_cpu_reset !== 1'b1) begin bad++; $display("FAIL bad_sticky err/cpu_rst got=%0b%0b exp=11", o_load_err, o_cpu_reset); end
        send_byte(8'hA5);
        total++; if (o_load_err !== 1'b0 || o_busy !== 1'b1) begin bad++; $display("FAIL bad_rehdr err/busy got=%0b%0b exp=01", o_load_err, o_busy); end
        seq = '{8'h03, 8'h05, 8'h83, 8'hE0, 8'h68};
        foreach (seq[i]) send_byte(seq[i]);
        total++; if (o_load_done !== 1'b1 || o_load_err !== 1'b0 || o_cpu_reset !== 1'b0) begin bad++; $display("FAIL bad_recover done/err/cpu_rst got=%0b%0b%0b exp=100", o_load_done, o_load_err, o_cpu_reset); end
        tick();
        total++; if (done_cnt !== 1 || w_addr.size() !== 6) begin bad++; $display("FAIL bad_recover_counts got done=%0d writes=%0d exp 1/6", done_cnt, w_addr.size()); end
    endtask

    task automatic test_garbage_random();
        do_reset(1'b0);
        seq = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h02, 8'h11, 8'h22, 8'h33};
        foreach (seq[i]) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) tick();
            send_byte(seq[i]);
        end
        tick();
        tick();
        total++; if (w_addr.size() !== 2) begin bad++; $display("FAIL garb_wr_count got=%0d exp=2", w_addr.size()); end
        if (w_addr.size() == 2) begin
            total++; if (w_addr[0] !== 8'h00 || w_addr[1] !== 8'h01) begin bad++; $display("FAIL garb_addr got=%02h,%02h exp=00,01", w_addr[0], w_addr[1]); end
            total++; if (w_data[0] !== 8'h11 || w_data[1] !== 8'h22) begin bad++; $display("FAIL garb_data got=%02h,%02h exp=11,22", w_data[0], w_data[1]); end
        end
        total++; if (done_cnt !== 1 || o_cpu_reset !== 1'b0 || o_load_err !== 1'b0) begin bad++; $display("FAIL garb_done got done=%0d cpu_rst=%0b err=%0b exp 1/0/0", done_cnt, o_cpu_reset, o_load_err); end
    endtask

    task automatic test_len_err();
        do_reset(1'b0);
        send_byte(8'hA5);
        send_byte(8'h00);
        total++; if (o_load_err !== 1'b1 || o_busy !== 1'b0 || o_cpu_reset !== 1'b1) begin bad++; $display("FAIL len0 err/busy/cpu_rst got=%0b%0b%0b exp=101", o_load_err, o_busy, o_cpu_reset); end
        do_reset(1'b1);
        send_byte(8'hA5);
        send_byte(8'h11);
        total++; if (o_load_err !== 1'b1 || o_busy !== 1'b0) begin bad++; $display("FAIL len11_aw4 err/busy got=%0b%0b exp=10", o_load_err, o_busy); end
        send_byte(8'hA5);
        send_byte(8'h10);
        total++; if (o_load_err !== 1'b0 || o_busy !== 1'b1) begin bad++; $display("FAIL len10_aw4 err/busy got=%0b%0b exp=01", o_load_err, o_busy); end
        total++; if (w_addr.size() !== 0) begin bad++; $display("FAIL len_no_we got=%0d exp=0", w_addr.size()); end
    endtask

    task automatic test_timeout();
        do_reset(1'b1);
        seq = '{8'hA5, 8'h04, 8'h11, 8'h22};
        foreach (seq[i]) send_byte(seq[i]);
        // Now in the cycle right after the last transfer (t+1).
        for (int k = 1; k <= 10; k++) begin
            total++; if (o_load_err !== 1'b0 || o_busy !== 1'b1) begin bad++; $display("FAIL tmo_early t+%0d err/busy got=%0b%0b exp=01", k, o_load_err, o_busy); end
            tick();
        end
        total++; if (o_load_err !== 1'b1 || o_busy !== 1'b0 || o_cpu_reset !== 1'b1) begin bad++; $display("FAIL tmo_fire t+11 err/busy/cpu_rst got=%0b%0b%0b exp=101", o_load_err, o_busy, o_cpu_reset); end
    endtask

    task automatic test_sync_reset_mid();
        logic [5:0] v;
        do_reset(1'b0);
        seq = '{8'hA5, 8'h05, 8'h11, 8'h22};
        foreach (seq[i]) send_byte(seq[i]);
        sync_reset = 1'b1;
        rx_valid   = 1'b1;
        rx_data    = 8'h33;
        tick();
        v = {o_cpu_reset, o_pm_we, o_load_done, o_load_err, o_busy, o_rx_ready};
        total++; if (v !== 6'b100000) begin bad++; $display("FAIL srst_flags got=%06b exp=100000", v); end
        total++; if (o_pm_wr_addr !== 8'h00 || o_pm_wr_data !== 8'h00) begin bad++; $display("FAIL srst_addr_data got=%02h/%02h exp=00/00", o_pm_wr_addr, o_pm_wr_data); end
        sync_reset = 1'b0;
        rx_valid   = 1'b0;
        total++; if (w_addr.size() !== 2) begin bad++; $display("FAIL srst_no_write got=%0d exp=2", w_addr.size()); end
        clear_mon();
        seq = '{8'hA5, 8'h02, 8'h44, 8'h55, 8'h99};
        foreach (seq[i]) send_byte(seq[i]);
        tick();
        total++;
        if (w_addr.size() !== 2 || done_cnt !== 1) begin
            bad++; $display("FAIL srst_restart got writes=%0d done=%0d exp 2/1", w_addr.size(), done_cnt);
        end else if (w_addr[0] !== 8'h00 || w_addr[1] !== 8'h01 || w_data[0] !== 8'h44 || w_data[1] !== 8'h55) begin
            bad++; $display("FAIL srst_restart got %02h=%02h %02h=%02h exp 00=44 01=55", w_addr[0], w_data[0], w_addr[1], w_data[1]);
        end
    endtask

    initial begin
        sel        = 1'b0;
        sync_reset = 1'b1;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        tick();
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_garbage_random();
        test_len_err();
        test_timeout();
        test_sync_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
